// File: rtl/vernam_pkg.sv
// Shared definitions for the Vernam link: default host port ids,
// status byte bit positions and the status count saturation helper.
package vernam_pkg;

  localparam logic [7:0] PT_PORT_DEF     = 8'h01;
  localparam logic [7:0] STATUS_PORT_DEF = 8'h02;

  localparam int ST_PT_VALID  = 0;
  localparam int ST_KEY_EMPTY = 1;
  localparam int ST_KEY_FULL  = 2;
  localparam int ST_OVERFLOW  = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_MSB = 7;

  // The status byte only has room for a 4-bit count, so larger fills read as 15.
  function automatic logic [3:0] satCount(input logic [8:0] count);
    return (count > 9'd15) ? 4'hF : count[3:0];
  endfunction

endpackage

// File: rtl/vernam_key_fifo.sv
// Synchronous key FIFO: one push and one pop per cycle, head is the oldest byte.
// A push into a full FIFO only succeeds when a pop frees a slot in the same cycle;
// otherwise the byte is dropped and drop_o pulses for that cycle.
module vernam_key_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    data_i,
  output logic [7:0]    head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          drop_o,
  output logic [AW:0]   count_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW:0]   count_q, count_d;
  logic          doPush, doPop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;

  assign doPop  = pop_i & ~empty_o;
  assign doPush = push_i & (~full_o | doPop);
  assign drop_o = push_i & ~doPush;

  // Next pointer and occupancy; pointers wrap naturally since DEPTH is 2**AW.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + AW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
    if (doPush && !doPop) count_d = count_q + (AW+1)'(1);
    if (doPop && !doPush) count_d = count_q - (AW+1)'(1);
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are meaningless while the slot is not counted.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/vernam_decipher.sv
// Receive end of the Vernam link: XORs each accepted ciphertext byte with the
// oldest buffered pad byte and holds the plaintext for the host PicoBlaze,
// which reads plaintext/status over its port bus and is interrupted on each byte.
module vernam_decipher
  import vernam_pkg::*;
#(
  parameter int         KEY_DEPTH   = 16,
  parameter int         KEY_AW      = 4,
  parameter logic [7:0] PT_PORT     = PT_PORT_DEF,
  parameter logic [7:0] STATUS_PORT = STATUS_PORT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_wr,
  input  logic [7:0] key_data,
  output logic       key_full,
  input  logic       ct_valid,
  input  logic [7:0] ct_data,
  output logic       ct_ready,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  output logic [7:0] rd_data,
  output logic       interrupt,
  input  logic       interrupt_ack
);

  logic [7:0]    keyHead;
  logic          keyEmpty, keyDrop;
  logic [KEY_AW:0] keyCount;
  logic          accept, ptRead, statusRead;
  logic [7:0]    ptReg_q, ptReg_d;
  logic          ptValid_q, ptValid_d;
  logic          overflow_q, overflow_d;
  logic          irq_q, irq_d;
  logic [7:0]    status;

  vernam_key_fifo #(
    .DEPTH (KEY_DEPTH),
    .AW    (KEY_AW)
  ) u_keyFifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (key_wr),
    .pop_i   (accept),
    .data_i  (key_data),
    .head_o  (keyHead),
    .full_o  (key_full),
    .empty_o (keyEmpty),
    .drop_o  (keyDrop),
    .count_o (keyCount)
  );

  assign ct_ready   = ~ptValid_q & ~keyEmpty;
  assign accept     = ct_valid & ct_ready;
  assign ptRead     = read_strobe & (port_id == PT_PORT);
  assign statusRead = read_strobe & (port_id == STATUS_PORT);
  assign interrupt  = irq_q;

  // Next plaintext, valid flag, sticky overflow and interrupt; set events beat clears.
  always_comb begin
    ptReg_d    = ptReg_q;
    ptValid_d  = ptValid_q;
    overflow_d = overflow_q;
    irq_d      = irq_q;
    if (accept) begin
      ptReg_d   = ct_data ^ keyHead;
      ptValid_d = 1'b1;
    end else if (ptRead) begin
      ptValid_d = 1'b0;
    end
    if (keyDrop)         overflow_d = 1'b1;
    else if (statusRead) overflow_d = 1'b0;
    if (accept)             irq_d = 1'b1;
    else if (interrupt_ack) irq_d = 1'b0;
  end

  // Holding register and flags; reset returns everything to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptReg_q    <= 8'h00;
      ptValid_q  <= 1'b0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ptReg_q    <= ptReg_d;
      ptValid_q  <= ptValid_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  // Assemble the status byte from current registered state.
  always_comb begin
    status = 8'h00;
    status[ST_PT_VALID]  = ptValid_q;
    status[ST_KEY_EMPTY] = keyEmpty;
    status[ST_KEY_FULL]  = key_full;
    status[ST_OVERFLOW]  = overflow_q;
    status[ST_COUNT_MSB:ST_COUNT_LSB] = satCount(9'(keyCount));
  end

  // Host read mux; unmapped port ids read as zero.
  always_comb begin
    rd_data = 8'h00;
    if (port_id == PT_PORT)          rd_data = ptReg_q;
    else if (port_id == STATUS_PORT) rd_data = status;
  end

endmodule
